// File: rtl/data_mem_pkg.sv
// Shared types and geometry helpers for the byte-lane data memory controller.
package data_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPLIT = 2'd1,
      RESP  = 2'd2
   } state_t;

   function automatic int lanesOf(input int dataW);
      return dataW / 8;
   endfunction

   function automatic int rowWidth(input int depthBytes, input int dataW);
      int rows;
      rows = depthBytes / (dataW / 8);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/mem_lane.sv
// One byte-wide storage lane: synchronous write, registered read with read enable.
module mem_lane #(
   parameter int ROWS    = 128,
   parameter int ROW_W   = 7,
   parameter int DATA_W  = 16,
   parameter int LANE    = 0,
   parameter     MEM_FILE = ""
) (
   input  logic             Clock,
   input  logic             we,
   input  logic             re,
   input  logic [ROW_W-1:0] row,
   input  logic [7:0]       wd,
   output logic [7:0]       rd
);

   logic [7:0] mem [ROWS];

   always_ff @(posedge Clock) begin
      if (we) mem[row] <= wd;
      if (re) rd <= mem[row];
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Big-endian byte-addressable data memory; misaligned words take two row accesses.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int DEPTH_BYTES = 256,
   parameter int ADDR_W      = 16,
   parameter     MEM_FILE    = ""
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic              ReqByte,
   input  logic [ADDR_W-1:0] Adresa,
   input  logic [DATA_W-1:0] WriteData,
   output logic              RespValid,
   output logic [DATA_W-1:0] ReadData,
   output logic              RespErr
);

   localparam int LANES = lanesOf(DATA_W);
   localparam int ROWS  = DEPTH_BYTES / LANES;
   localparam int ROW_W = rowWidth(DEPTH_BYTES, DATA_W);
   localparam int OFF_W = $clog2(LANES);

   state_t state, nextState;

   logic [ROW_W-1:0]  rowQ;
   logic [OFF_W-1:0]  offQ;
   logic [DATA_W-1:0] wdQ;
   logic              writeQ, byteQ, errQ;

   logic [LANES-1:0]            laneWe, laneRe;
   logic [LANES-1:0][ROW_W-1:0] laneRow;
   logic [LANES-1:0][7:0]       laneWd, laneRd;

   logic              accept, outOfRange;
   logic [OFF_W-1:0]  off;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W:0]   lastByte;

   // Byte k of a word counts from the MSB, matching big-endian address order.
   function automatic logic [7:0] wordByte(input logic [DATA_W-1:0] w, input logic [OFF_W-1:0] k);
      return w[DATA_W-1-8*int'(k) -: 8];
   endfunction

   assign ReqReady   = (state == IDLE) && !Reset;
   assign accept     = ReqValid && ReqReady;
   assign off        = Adresa[OFF_W-1:0];
   assign row        = ROW_W'(Adresa >> OFF_W);
   // One extra bit so the last-byte address cannot wrap back into range.
   assign lastByte   = {1'b0, Adresa} + (ReqByte ? '0 : (ADDR_W+1)'(LANES-1));
   assign outOfRange = lastByte >= (ADDR_W+1)'(DEPTH_BYTES);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         rowQ   <= '0;
         offQ   <= '0;
         wdQ    <= '0;
         writeQ <= 1'b0;
         byteQ  <= 1'b0;
         errQ   <= 1'b0;
      end else begin
         state <= nextState;
         if (accept) begin
            rowQ   <= row;
            offQ   <= off;
            wdQ    <= WriteData;
            writeQ <= ReqWrite;
            byteQ  <= ReqByte;
            errQ   <= outOfRange;
         end
      end
   end

   always_comb begin
      nextState = state;
      laneWe    = '0;
      laneRe    = '0;
      laneRow   = '0;
      laneWd    = '0;
      unique case (state)
         IDLE: if (accept) begin
            nextState = (outOfRange || ReqByte || off == '0) ? RESP : SPLIT;
            if (!outOfRange) begin
               if (ReqByte) begin
                  laneRow[off] = row;
                  laneWe[off]  = ReqWrite;
                  laneRe[off]  = !ReqWrite;
                  laneWd[off]  = WriteData[7:0];
               end else begin
                  for (int l = 0; l < LANES; l++) begin
                     if (l >= int'(off)) begin
                        laneRow[l] = row;
                        laneWe[l]  = ReqWrite;
                        laneRe[l]  = !ReqWrite;
                        laneWd[l]  = wordByte(WriteData, OFF_W'(l) - off);
                     end
                  end
               end
            end
         end
         SPLIT: begin
            nextState = RESP;
            for (int l = 0; l < LANES; l++) begin
               if (l < int'(offQ)) begin
                  laneRow[l] = rowQ + ROW_W'(1);
                  laneWe[l]  = writeQ;
                  laneRe[l]  = !writeQ;
                  laneWd[l]  = wordByte(wdQ, OFF_W'(l) - offQ);
               end
            end
         end
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Lanes hold their read bytes until RESP; rotate by the offset to restore word order.
   always_comb begin
      ReadData = '0;
      if (state == RESP && !errQ && !writeQ) begin
         if (byteQ) begin
            ReadData[7:0] = laneRd[offQ];
         end else begin
            for (int k = 0; k < LANES; k++)
               ReadData[DATA_W-1-8*k -: 8] = laneRd[offQ + OFF_W'(k)];
         end
      end
   end

   assign RespValid = (state == RESP);
   assign RespErr   = (state == RESP) && errQ;

   for (genvar g = 0; g < LANES; g++) begin : gLane
      mem_lane #(
         .ROWS     (ROWS),
         .ROW_W    (ROW_W),
         .DATA_W   (DATA_W),
         .LANE     (g),
         .MEM_FILE (MEM_FILE)
      ) uLane (
         .Clock (Clock),
         .we    (laneWe[g]),
         .re    (laneRe[g]),
         .row   (laneRow[g]),
         .wd    (laneWd[g]),
         .rd    (laneRd[g])
      );
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed vector bench for data_mem_ctrl at default parameters (16-bit words, 256 bytes).
module tb_data_mem_ctrl;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic        ReqWrite = 1'b0;
   logic        ReqByte = 1'b0;
   logic [15:0] Adresa = '0;
   logic [15:0] WriteData = '0;
   logic        RespValid;
   logic [15:0] ReadData;
   logic        RespErr;

   int checks = 0;
   int failures = 0;

   data_mem_ctrl #(
      .DATA_W(16), .DEPTH_BYTES(256), .ADDR_W(16), .MEM_FILE("")
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .ReqValid  (ReqValid),
      .ReqReady  (ReqReady),
      .ReqWrite  (ReqWrite),
      .ReqByte   (ReqByte),
      .Adresa    (Adresa),
      .WriteData (WriteData),
      .RespValid (RespValid),
      .ReadData  (ReadData),
      .RespErr   (RespErr)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      string       name;
      bit          wr;
      bit          by;
      logic [15:0] addr;
      logic [15:0] wd;
      logic [15:0] expRd;
      bit          expErr;
      int          expLat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic addVec(input string name, input bit wr, input bit by, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [15:0] expRd, input bit expErr,
                         input int expLat);
      vec_t v;
      v.name = name; v.wr = wr; v.by = by; v.addr = addr; v.wd = wd;
      v.expRd = expRd; v.expErr = expErr; v.expLat = expLat;
      vecs.push_back(v);
   endtask

   // Drive at negedge, hold until accepted, then count cycles to RespValid (lat=-1 on timeout).
   task automatic doReq(input bit wr, input bit by, input logic [15:0] addr, input logic [15:0] wd,
                        output logic [15:0] rd, output bit err, output int lat, output bit rdyLow);
      bit acc;
      acc = 0; rd = '0; err = 0; lat = -1; rdyLow = 0;
      @(negedge Clock);
      ReqValid = 1; ReqWrite = wr; ReqByte = by; Adresa = addr; WriteData = wd;
      for (int i = 0; i < 10 && !acc; i++) begin
         if (ReqReady) acc = 1;
         @(negedge Clock);
      end
      ReqValid = 0;
      if (!acc) begin
         checks++; failures++;
         $display("FAIL accept_timeout: addr %0h never accepted", addr);
         return;
      end
      rdyLow = !ReqReady;
      for (int n = 1; n <= 10; n++) begin
         if (RespValid) begin
            lat = n; rd = ReadData; err = RespErr;
            return;
         end
         @(negedge Clock);
      end
   endtask

   initial begin
      logic [15:0] rd;
      bit          err, rdyLow, sawResp, prevV;
      int          lat, pulses, consec;

      addVec("w_beef_10",    1, 0, 16'h0010, 16'hBEEF, 16'h0000, 0, 1);
      addVec("r_w_10",       0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1);
      addVec("r_b_10",       0, 1, 16'h0010, 16'h0000, 16'h00BE, 0, 1);
      addVec("r_b_11",       0, 1, 16'h0011, 16'h0000, 16'h00EF, 0, 1);
      addVec("w_1234_11",    1, 0, 16'h0011, 16'h1234, 16'h0000, 0, 2);
      addVec("r_w_11",       0, 0, 16'h0011, 16'h0000, 16'h1234, 0, 2);
      addVec("r_b_12",       0, 1, 16'h0012, 16'h0000, 16'h0034, 0, 1);
      addVec("w_0000_20",    1, 0, 16'h0020, 16'h0000, 16'h0000, 0, 1);
      addVec("w_b_a5_21",    1, 1, 16'h0021, 16'h77A5, 16'h0000, 0, 1);
      addVec("r_w_20",       0, 0, 16'h0020, 16'h0000, 16'h00A5, 0, 1);
      addVec("r_b_21",       0, 1, 16'h0021, 16'h0000, 16'h00A5, 0, 1);
      addVec("w_b_5a_ff",    1, 1, 16'h00FF, 16'h005A, 16'h0000, 0, 1);
      addVec("r_w_ff_err",   0, 0, 16'h00FF, 16'h0000, 16'h0000, 1, 1);
      addVec("w_w_ff_err",   1, 0, 16'h00FF, 16'hDEAD, 16'h0000, 1, 1);
      addVec("r_b_ff_kept",  0, 1, 16'h00FF, 16'h0000, 16'h005A, 0, 1);
      addVec("w_1357_fe",    1, 0, 16'h00FE, 16'h1357, 16'h0000, 0, 1);
      addVec("r_w_fe",       0, 0, 16'h00FE, 16'h0000, 16'h1357, 0, 1);
      addVec("r_w_100_err",  0, 0, 16'h0100, 16'h0000, 16'h0000, 1, 1);
      addVec("r_b_ffff_err", 0, 1, 16'hFFFF, 16'h0000, 16'h0000, 1, 1);
      addVec("w_abcd_21",    1, 0, 16'h0021, 16'hABCD, 16'h0000, 0, 2);
      addVec("r_w_20_b",     0, 0, 16'h0020, 16'h0000, 16'h00AB, 0, 1);
      addVec("r_b_22",       0, 1, 16'h0022, 16'h0000, 16'h00CD, 0, 1);

      // Reset state
      #12;
      chk("rst_respvalid", RespValid, 0);
      chk("rst_resperr",   RespErr, 0);
      chk("rst_readdata",  ReadData, 0);
      @(negedge Clock); Reset = 0;
      @(negedge Clock);
      chk("rst_ready", ReqReady, 1);

      foreach (vecs[i]) begin
         doReq(vecs[i].wr, vecs[i].by, vecs[i].addr, vecs[i].wd, rd, err, lat, rdyLow);
         chk({vecs[i].name, "_rd"},  rd,  vecs[i].expRd);
         chk({vecs[i].name, "_err"}, err, vecs[i].expErr);
         chk({vecs[i].name, "_lat"}, lat, vecs[i].expLat);
         if (vecs[i].expLat == 2) chk({vecs[i].name, "_split_ready"}, rdyLow, 1);
      end

      // Reset in the middle of a misaligned write
      doReq(1, 0, 16'h0030, 16'h1111, rd, err, lat, rdyLow);
      doReq(1, 0, 16'h0032, 16'h2222, rd, err, lat, rdyLow);
      @(negedge Clock);
      ReqValid = 1; ReqWrite = 1; ReqByte = 0; Adresa = 16'h0031; WriteData = 16'hCAFE;
      @(negedge Clock);
      ReqValid = 0;
      chk("split_ready_low", ReqReady, 0);
      chk("split_no_resp",   RespValid, 0);
      Reset = 1;
      #1;
      chk("rst_mid_respvalid", RespValid, 0);
      chk("rst_mid_readdata",  ReadData, 0);
      sawResp = RespValid;
      repeat (3) begin @(negedge Clock); sawResp |= RespValid; end
      Reset = 0;
      repeat (4) begin @(negedge Clock); sawResp |= RespValid; end
      chk("abort_no_resp", sawResp, 0);
      chk("abort_ready",   ReqReady, 1);
      doReq(0, 1, 16'h0031, 16'h0000, rd, err, lat, rdyLow);
      chk("abort_b_31", rd, 16'h00CA);
      doReq(0, 1, 16'h0032, 16'h0000, rd, err, lat, rdyLow);
      chk("abort_b_32", rd, 16'h0022);
      doReq(0, 1, 16'h0030, 16'h0000, rd, err, lat, rdyLow);
      chk("abort_b_30", rd, 16'h0011);

      // ReqValid held high: one accept per IDLE cycle, a response every other cycle
      @(negedge Clock);
      ReqValid = 1; ReqWrite = 0; ReqByte = 0; Adresa = 16'h0010;
      pulses = 0; consec = 0; prevV = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (RespValid) begin
            pulses++;
            if (prevV) consec++;
            chk("b2b_data", ReadData, 16'hBE12);
         end
         prevV = RespValid;
      end
      ReqValid = 0;
      chk("b2b_pulses", pulses, 4);
      chk("b2b_consec", consec, 0);
      repeat (3) @(negedge Clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
